// File: rtl/podium_sprite_ctrl_if.sv
// ---------------------------------------------------------------------------
// podium_sprite_ctrl_if
// Target-position handshake between a position source and podium_sprite_ctrl.
//   tgt_x     [9:0]  requested slab centre x
//   tgt_y     [9:0]  requested slab bottom-edge y
//   tgt_valid        target offered by the master
//   tgt_ready        sprite can accept a target (high only while idle)
// ---------------------------------------------------------------------------
interface podium_sprite_ctrl_if;
  logic [9:0] tgt_x;
  logic [9:0] tgt_y;
  logic       tgt_valid;
  logic       tgt_ready;

  modport master (output tgt_x, output tgt_y, output tgt_valid, input tgt_ready);
  modport slave  (input tgt_x, input tgt_y, input tgt_valid, output tgt_ready);
endinterface

// File: rtl/podium_sprite_ctrl.sv
// ---------------------------------------------------------------------------
// podium_sprite_ctrl
// VGA podium sprite (top slab plus NUM_LEGS legs) composited over a background
// layer. A target position is accepted over a valid/ready handshake and the
// sprite slides toward it by at most STEP px per axis per frame. The position
// only changes at the end-of-frame tick, so a frame is never drawn half-moved.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   bright              display-area flag
//   hCount, vCount      current column / row
//   background [11:0]   colour of the layer underneath
//   tgt                 target handshake (slave side)
//   rgb [11:0]          composited pixel, one cycle latency
//   hit                 pixel belongs to the podium, aligned with rgb
//   moving              high while sliding toward a target
//
// Optional build macro: PODIUM_OUTLINE_EN -- darkens (COLOR>>1 per channel)
// podium pixels lying on the perimeter of any slab/leg rectangle.
//
// state | meaning
// IDLE  | at rest, tgt_ready high, waiting for a target
// MOVE  | stepping toward the latched target once per frame tick
// ---------------------------------------------------------------------------
module podium_sprite_ctrl #(
  parameter int          TOP_W    = 60,
  parameter int          TOP_H    = 10,
  parameter int          LEG_W    = 15,
  parameter int          LEG_H    = 40,
  parameter int          NUM_LEGS = 2,
  parameter int          STEP     = 4,
  parameter int          X_INIT   = 250,
  parameter int          Y_INIT   = 215,
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          H_LAST   = 799,
  parameter int          V_LAST   = 524,
  parameter logic [11:0] COLOR    = 12'h840
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bright,
  input  logic [9:0]                 hCount,
  input  logic [9:0]                 vCount,
  input  logic [11:0]                background,
  podium_sprite_ctrl_if.slave        tgt,
  output logic [11:0]                rgb,
  output logic                       hit,
  output logic                       moving
);

  typedef enum logic [0:0] {IDLE, MOVE} state_t;

  localparam logic signed [10:0] TW2  = 11'(TOP_W / 2);
  localparam logic signed [10:0] TH   = 11'(TOP_H);
  localparam logic signed [10:0] LW2  = 11'(LEG_W / 2);
  localparam logic signed [10:0] LH   = 11'(LEG_H);
  localparam logic signed [10:0] STP  = 11'(STEP);
  localparam int                 LEG_DIV = (NUM_LEGS > 1) ? NUM_LEGS - 1 : 1;

  localparam logic [9:0] X_MIN = 10'(TOP_W / 2);
  localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1 - TOP_W / 2);
  localparam logic [9:0] Y_MIN = 10'(TOP_H);
  localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1 - LEG_H);

  state_t             state_q, state_d;
  logic signed [10:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic signed [10:0] tx_q, tx_d, ty_q, ty_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               hit_q, hit_d;

  logic frame_tick, xfer;

  // Leg centre offset from the slab centre.
  function automatic logic signed [10:0] leg_off(input int k);
    if (NUM_LEGS == 1) return 11'sd0;
    return 11'(LEG_W / 2 - TOP_W / 2 + k * (TOP_W - LEG_W) / LEG_DIV);
  endfunction

  function automatic logic [9:0] clamp10(input logic [9:0] val, input logic [9:0] lo,
                                         input logic [9:0] hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

  // One frame's movement: jump to the target when within STEP, else STEP toward it.
  function automatic logic signed [10:0] step_to(input logic signed [10:0] p,
                                                 input logic signed [10:0] t);
    logic signed [10:0] d;
    d = t - p;
    if (d > STP)  return p + STP;
    if (d < -STP) return p - STP;
    return t;
  endfunction

  assign frame_tick    = (hCount == 10'(H_LAST)) && (vCount == 10'(V_LAST));
  assign tgt.tgt_ready = (state_q == IDLE);
  assign xfer          = tgt.tgt_valid && tgt.tgt_ready;
  assign moving        = (state_q == MOVE);
  assign rgb           = rgb_q;
  assign hit           = hit_q;

  // Transfers only happen in IDLE, so a transfer coinciding with the frame tick
  // naturally takes no step that tick.
  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          tx_d    = $signed({1'b0, clamp10(tgt.tgt_x, X_MIN, X_MAX)});
          ty_d    = $signed({1'b0, clamp10(tgt.tgt_y, Y_MIN, Y_MAX)});
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (frame_tick) begin
          xpos_d = step_to(xpos_q, tx_q);
          ypos_d = step_to(ypos_q, ty_q);
          if (xpos_d == tx_q && ypos_d == ty_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel classification in signed 11-bit so bounds near the screen edge
  // go negative instead of wrapping to large unsigned values.
  always_comb begin
    logic signed [10:0] h_s, v_s, cx;
    logic               in_pod;
    logic               on_edge;
    h_s     = $signed({1'b0, hCount});
    v_s     = $signed({1'b0, vCount});
    in_pod  = 1'b0;
    on_edge = 1'b0;
    cx      = '0;

    if (v_s >= ypos_q - TH && v_s <= ypos_q &&
        h_s >= xpos_q - TW2 && h_s <= xpos_q + TW2) begin
      in_pod = 1'b1;
      if (v_s == ypos_q - TH || v_s == ypos_q ||
          h_s == xpos_q - TW2 || h_s == xpos_q + TW2) on_edge = 1'b1;
    end

    for (int k = 0; k < NUM_LEGS; k++) begin
      cx = xpos_q + leg_off(k);
      if (v_s > ypos_q && v_s <= ypos_q + LH &&
          h_s >= cx - LW2 && h_s <= cx + LW2) begin
        in_pod = 1'b1;
        if (v_s == ypos_q + 11'sd1 || v_s == ypos_q + LH ||
            h_s == cx - LW2 || h_s == cx + LW2) on_edge = 1'b1;
      end
    end

    rgb_d = background;
    hit_d = 1'b0;
    if (!bright) begin
      rgb_d = '0;
    end else if (in_pod) begin
      hit_d = 1'b1;
`ifdef PODIUM_OUTLINE_EN
      rgb_d = on_edge ? {1'b0, COLOR[11:9], 1'b0, COLOR[7:5], 1'b0, COLOR[3:1]} : COLOR;
`else
      rgb_d = COLOR;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xpos_q  <= 11'(X_INIT);
      ypos_q  <= 11'(Y_INIT);
      tx_q    <= 11'(X_INIT);
      ty_q    <= 11'(Y_INIT);
      rgb_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      rgb_q   <= rgb_d;
      hit_q   <= hit_d;
    end
  end

endmodule

// File: tb/tb_podium_sprite_ctrl.sv
// ---------------------------------------------------------------------------
// tb_podium_sprite_ctrl
// Self-checking bench: an integer model of the sprite (position, target,
// rectangle membership) predicts every output each cycle; a few literal
// expectations pin the model. hCount/vCount are driven directly so the frame
// tick can be produced on demand.
// ---------------------------------------------------------------------------
module tb_podium_sprite_ctrl;
  localparam int TOP_W = 60, TOP_H = 10, LEG_W = 15, LEG_H = 40, NUM_LEGS = 2;
  localparam int STEP = 4, X_INIT = 250, Y_INIT = 215;
  localparam int COLOR = 'h840, DARK = 'h420;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hc = '0, vc = '0;
  logic [11:0] bg = '0;
  logic [11:0] rgb;
  logic        hit, moving;

  podium_sprite_ctrl_if tif ();

  podium_sprite_ctrl dut (
    .clk(clk), .rst(rst), .bright(bright), .hCount(hc), .vCount(vc),
    .background(bg), .tgt(tif.slave), .rgb(rgb), .hit(hit), .moving(moving)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  int  mx, my, mtx, mty;
  bit  busy;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int clampi(input int a, input int lo, input int hi);
    return (a < lo) ? lo : (a > hi) ? hi : a;
  endfunction

  // part 0 is the slab, parts 1..NUM_LEGS are the legs
  function automatic bit in_part(input int p, input int h, input int v, input int x, input int y);
    int cx;
    if (p == 0) return (v >= y - TOP_H) && (v <= y) && (iabs(h - x) <= TOP_W / 2);
    cx = (NUM_LEGS == 1) ? x
       : x - TOP_W / 2 + LEG_W / 2 + (p - 1) * (TOP_W - LEG_W) / (NUM_LEGS - 1);
    return (v > y) && (v <= y + LEG_H) && (iabs(h - cx) <= LEG_W / 2);
  endfunction

  function automatic int exp_pixel(input bit br, input int h, input int v, input int b,
                                   input int x, input int y, output bit eh);
    bit any, edg;
    any = 0; edg = 0; eh = 0;
    for (int p = 0; p <= NUM_LEGS; p++) begin
      if (in_part(p, h, v, x, y)) begin
        any = 1;
        if (!(in_part(p, h - 1, v, x, y) && in_part(p, h + 1, v, x, y) &&
              in_part(p, h, v - 1, x, y) && in_part(p, h, v + 1, x, y))) edg = 1;
      end
    end
    if (!br) return 0;
    if (!any) return b;
    eh = 1;
`ifdef PODIUM_OUTLINE_EN
    return edg ? DARK : COLOR;
`else
    return COLOR;
`endif
  endfunction

  function automatic int toward(input int p, input int t);
    int d, m;
    d = t - p;
    m = (iabs(d) < STEP) ? iabs(d) : STEP;
    return (d < 0) ? p - m : p + m;
  endfunction

  task automatic model_reset();
    mx = X_INIT; my = Y_INIT; mtx = X_INIT; mty = Y_INIT; busy = 0;
  endtask

  // One clock: predict, advance model at the edge, compare everything.
  task automatic cycle();
    int er; bit eh; bit tick;
    er = exp_pixel(bright, int'(hc), int'(vc), int'(bg), mx, my, eh);
    tick = (hc == 10'd799) && (vc == 10'd524);
    @(posedge clk);
    if (!busy) begin
      if (tif.tgt_valid) begin
        mtx = clampi(int'(tif.tgt_x), TOP_W / 2, 640 - 1 - TOP_W / 2);
        mty = clampi(int'(tif.tgt_y), TOP_H, 480 - 1 - LEG_H);
        busy = 1;
      end
    end else if (tick) begin
      mx = toward(mx, mtx);
      my = toward(my, mty);
      if (mx == mtx && my == mty) busy = 0;
    end
    #1;
    check("rgb", int'(rgb), er);
    check("hit", int'(hit), int'(eh));
    check("moving", int'(moving), int'(busy));
    check("tgt_ready", int'(tif.tgt_ready), int'(!busy));
    check("xpos", int'(dut.xpos_q), mx);
    check("ypos", int'(dut.ypos_q), my);
  endtask

  task automatic tick_frame();
    hc = 10'd799; vc = 10'd524;
    cycle();
    hc = 10'd0; vc = 10'd0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rgb"}, int'(rgb), 0);
    check({tag, "_hit"}, int'(hit), 0);
    check({tag, "_moving"}, int'(moving), 0);
    check({tag, "_ready"}, int'(tif.tgt_ready), 1);
    check({tag, "_xpos"}, int'(dut.xpos_q), 250);
    check({tag, "_ypos"}, int'(dut.ypos_q), 215);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tif.tgt_x = '0; tif.tgt_y = '0; tif.tgt_valid = 1'b0;
    #1 rst = 1'b1;
    #3;
    reset_checks("reset");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // draw / background / blank
    bright = 1; hc = 10'd250; vc = 10'd210; bg = 12'h00F;
    cycle();
    check("draw_rgb", int'(rgb), 'h840);
    check("draw_hit", int'(hit), 1);
    hc = 10'd220; vc = 10'd205;
    cycle();
`ifdef PODIUM_OUTLINE_EN
    check("outline_rgb", int'(rgb), 'h420);
`else
    check("corner_rgb", int'(rgb), 'h840);
`endif
    hc = 10'd10; vc = 10'd210;
    cycle();
    check("bg_rgb", int'(rgb), 'h00F);
    check("bg_hit", int'(hit), 0);
    bright = 0; hc = 10'd250;
    cycle();
    check("blank_rgb", int'(rgb), 0);
    check("blank_hit", int'(hit), 0);

    // slide 250 -> 260
    tif.tgt_x = 10'd260; tif.tgt_y = 10'd215; tif.tgt_valid = 1;
    hc = 10'd0; vc = 10'd0;
    cycle();
    tif.tgt_valid = 0;
    check("slide_ready", int'(tif.tgt_ready), 0);
    check("slide_moving", int'(moving), 1);
    cycle();
    tick_frame();
    check("slide_x1", int'(dut.xpos_q), 254);
    check("slide_mv1", int'(moving), 1);
    cycle();
    tick_frame();
    check("slide_x2", int'(dut.xpos_q), 258);
    check("slide_rdy2", int'(tif.tgt_ready), 0);
    tick_frame();
    check("slide_x3", int'(dut.xpos_q), 260);
    check("slide_mv3", int'(moving), 0);

    // transfer on the tick itself, clamped target (5,470) -> (30,439)
    tif.tgt_x = 10'd5; tif.tgt_y = 10'd470; tif.tgt_valid = 1;
    hc = 10'd799; vc = 10'd524;
    cycle();
    tif.tgt_valid = 0; hc = 10'd0; vc = 10'd0;
    check("xfer_tick_x", int'(dut.xpos_q), 260);
    check("xfer_tick_mv", int'(moving), 1);
    n = 0;
    while (moving && n < 100) begin
      tick_frame();
      n++;
    end
    check("clamp_done", int'(moving), 0);
    check("clamp_x", int'(dut.xpos_q), 30);
    check("clamp_y", int'(dut.ypos_q), 439);
    bright = 1; bg = 12'h0F0; hc = 10'd0; vc = 10'd435;
    cycle();
`ifdef PODIUM_OUTLINE_EN
    check("edge_h0_rgb", int'(rgb), 'h420);
`else
    check("edge_h0_rgb", int'(rgb), 'h840);
`endif
    check("edge_h0_hit", int'(hit), 1);
    hc = 10'd1;
    cycle();
    check("edge_h1_rgb", int'(rgb), 'h840);
    hc = 10'd1023;
    cycle();
    check("wrap_rgb", int'(rgb), 'h0F0);
    check("wrap_hit", int'(hit), 0);

    // reset in the middle of a move
    tif.tgt_x = 10'd400; tif.tgt_y = 10'd300; tif.tgt_valid = 1;
    cycle();
    tif.tgt_valid = 0;
    tick_frame();
    tick_frame();
    #2 rst = 1'b1;
    #1;
    reset_checks("midrst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    tick_frame();
    check("midrst_stay_x", int'(dut.xpos_q), 250);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bright = ($urandom_range(0, 9) != 0);
      bg = 12'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        hc = 10'd799; vc = 10'd524;
      end else if ($urandom_range(0, 1) == 1) begin
        hc = 10'(clampi(mx + int'($urandom_range(0, 80)) - 40, 0, 1023));
        vc = 10'(clampi(my + int'($urandom_range(0, 60)) - 15, 0, 1023));
      end else begin
        hc = 10'($urandom_range(0, 1023));
        vc = 10'($urandom_range(0, 1023));
      end
      tif.tgt_valid = ($urandom_range(0, 3) == 0);
      tif.tgt_x = 10'($urandom_range(0, 1023));
      tif.tgt_y = 10'($urandom_range(0, 1023));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
